// File: rtl/sifreleme_pkg.sv
// Shared types and constants for the serial cipher transmitter: state
// encoding, key-table depth and the power-on key set.
package sifreleme_pkg;

    localparam int ANAHTAR_DERINLIK = 8;

    typedef enum logic {
        BOSTA  = 1'b0,
        GONDER = 1'b1
    } durum_t;

    function automatic logic [63:0] varsayilan_anahtar(input logic [2:0] indeks);
        logic [63:0] k;
        case (indeks)
            3'd0:    k = 64'hBABA_1453_DEDE_1071;
            3'd1:    k = 64'hACAB_0909_BACA_0707;
            3'd2:    k = 64'hADAB_0606_DADA_0505;
            3'd3:    k = 64'hAAAA_0000_FFFF_5555;
            3'd4:    k = 64'hCAAA_0101_CAAA_0101;
            3'd5:    k = 64'hAACA_0606_AACA_0606;
            3'd6:    k = 64'hCAAA_1717_CAAA_1717;
            default: k = 64'hAAAA_0000_FFFF_5555;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/sifreli_seri_verici_if.sv
// Word-in / bit-out handshake bundle of the serial cipher transmitter.
// master = the side issuing words and consuming bits, slave = the transmitter.
interface sifreli_seri_verici_if #(
    parameter int BIT = 8
);
    logic           basla;
    logic           mod;
    logic [BIT-1:0] veri;
    logic [2:0]     secim;
    logic           alici_hazir;
    logic           hazir;
    logic           bit_cikisi;
    logic           gecerli;
    logic           son;

    modport master (
        output basla, mod, veri, secim, alici_hazir,
        input  hazir, bit_cikisi, gecerli, son
    );

    modport slave (
        input  basla, mod, veri, secim, alici_hazir,
        output hazir, bit_cikisi, gecerli, son
    );
endinterface

// File: rtl/anahtar_tablosu.sv
// 8x64 key register file: reset loads the package defaults, one synchronous
// write port, one combinational read port returning the low OKU_W bits.
module anahtar_tablosu
    import sifreleme_pkg::*;
#(
    parameter int OKU_W = 64
) (
    input  logic             saat,
    input  logic             reset,
    input  logic             yaz,
    input  logic [2:0]       yaz_adres,
    input  logic [63:0]      yaz_veri,
    input  logic [2:0]       oku_adres,
    output logic [OKU_W-1:0] oku_veri
);

    logic [63:0] tablo_q [ANAHTAR_DERINLIK];
    logic [63:0] tablo_d [ANAHTAR_DERINLIK];

    always_comb begin
        for (int i = 0; i < ANAHTAR_DERINLIK; i++) begin
            tablo_d[i] = tablo_q[i];
        end
        if (yaz) begin
            tablo_d[yaz_adres] = yaz_veri;
        end
    end

    always_ff @(posedge saat or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ANAHTAR_DERINLIK; i++) begin
                tablo_q[i] <= varsayilan_anahtar(3'(i));
            end
        end else begin
            for (int i = 0; i < ANAHTAR_DERINLIK; i++) begin
                tablo_q[i] <= tablo_d[i];
            end
        end
    end

    // Read sees the stored value, so a write on the same edge is not visible yet.
    assign oku_veri = tablo_q[oku_adres][OKU_W-1:0];

endmodule

// File: rtl/sifreli_seri_verici.sv
// Serial cipher transmitter: XOR with a table key plus rotation, then one bit
// per downstream handshake with a last-bit flag and back-to-back acceptance.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   BOSTA  | idle, gecerli=0, waiting for basla
//   GONDER | streaming a word, gecerli=1, advances on alici_hazir
module sifreli_seri_verici
    import sifreleme_pkg::*;
#(
    parameter int BIT     = 8,
    parameter int ROT     = 2,
    parameter int ILK_MSB = 0
) (
    input  logic                saat,
    input  logic                reset,
    input  logic                anahtar_yaz,
    input  logic [2:0]          anahtar_adres,
    input  logic [63:0]         anahtar_veri,
    sifreli_seri_verici_if.slave bus
);

    localparam int CW = $clog2(BIT);
    localparam int R  = ROT % BIT;

    logic [BIT-1:0] anahtar;
    logic [BIT-1:0] xorlu;
    logic [BIT-1:0] sifreli;
    logic [BIT-1:0] donmus;
    logic [BIT-1:0] sonuc;
    logic           kabul;

    durum_t         durum_q, durum_d;
    logic [BIT-1:0] kay_q, kay_d;
    logic [CW-1:0]  say_q, say_d;
    logic           bit_q, bit_d;
    logic           gecerli_q, gecerli_d;
    logic           son_q, son_d;

    anahtar_tablosu #(.OKU_W(BIT)) u_anahtar_tablosu (
        .saat      (saat),
        .reset     (reset),
        .yaz       (anahtar_yaz),
        .yaz_adres (anahtar_adres),
        .yaz_veri  (anahtar_veri),
        .oku_adres (bus.secim),
        .oku_veri  (anahtar)
    );

    // Encrypt: rotl(veri ^ K); decrypt: rotr(veri) ^ K, the exact inverse.
    always_comb begin
        xorlu   = bus.veri ^ anahtar;
        sifreli = '0;
        donmus  = '0;
        for (int i = 0; i < BIT; i++) begin
            sifreli[(i + R) % BIT] = xorlu[i];
            donmus[i]              = bus.veri[(i + R) % BIT];
        end
        sonuc = bus.mod ? sifreli : (donmus ^ anahtar);
    end

    assign bus.hazir = ~gecerli_q | (son_q & bus.alici_hazir);
    assign kabul     = bus.basla & bus.hazir;

    always_comb begin
        durum_d   = durum_q;
        kay_d     = kay_q;
        say_d     = say_q;
        bit_d     = bit_q;
        gecerli_d = gecerli_q;
        son_d     = son_q;
        if (kabul) begin
            durum_d   = GONDER;
            kay_d     = sonuc;
            say_d     = '0;
            bit_d     = (ILK_MSB != 0) ? sonuc[BIT-1] : sonuc[0];
            gecerli_d = 1'b1;
            son_d     = 1'b0;
        end else if (durum_q == GONDER && bus.alici_hazir) begin
            if (son_q) begin
                durum_d   = BOSTA;
                bit_d     = 1'b0;
                gecerli_d = 1'b0;
                son_d     = 1'b0;
            end else begin
                kay_d = (ILK_MSB != 0) ? (kay_q << 1) : (kay_q >> 1);
                bit_d = (ILK_MSB != 0) ? kay_q[BIT-2] : kay_q[1];
                say_d = say_q + CW'(1);
                son_d = (say_q == CW'(BIT - 2));
            end
        end
    end

    always_ff @(posedge saat or negedge reset) begin
        if (!reset) begin
            durum_q   <= BOSTA;
            kay_q     <= '0;
            say_q     <= '0;
            bit_q     <= 1'b0;
            gecerli_q <= 1'b0;
            son_q     <= 1'b0;
        end else begin
            durum_q   <= durum_d;
            kay_q     <= kay_d;
            say_q     <= say_d;
            bit_q     <= bit_d;
            gecerli_q <= gecerli_d;
            son_q     <= son_d;
        end
    end

    assign bus.bit_cikisi = bit_q;
    assign bus.gecerli    = gecerli_q;
    assign bus.son        = son_q;

endmodule

// File: doc/sifreli_seri_verici.md
Name: sifreli_seri_verici

Overview:
- Parametrised successor to the team's single-word serial cipher.
- Takes a BIT-wide word and XOR-ciphers it with a key from a run-time writable 8-entry key table.
- Rotates the result by a parameterised amount, then streams it out one bit per handshake.
- Adds downstream back-pressure, a last-bit flag, a true inverse decrypt mode, selectable bit order and back-to-back word acceptance.

Parameters:
- BIT, 8, word width; legal range 2..64.
- ROT, 2, rotate amount; applied modulo BIT.
- ILK_MSB, 0, output bit order: 0 = LSB first, 1 = MSB first.

Ports:
- saat  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- basla  input  1  start request; accepted only on an edge where hazir=1.
- mod  input  1  1 = encrypt, 0 = decrypt; sampled at acceptance.
- veri  input  BIT  plaintext or ciphertext word; sampled at acceptance.
- secim  input  3  key index; sampled at acceptance.
- anahtar_yaz  input  1  key-table write enable.
- anahtar_adres  input  3  key-table write index.
- anahtar_veri  input  64  key-table write data.
- alici_hazir  input  1  downstream ready; a bit is consumed on an edge where gecerli=1 and alici_hazir=1.
- hazir  output  1  block can accept basla this cycle (combinational).
- bit_cikisi  output  1  current serial bit (registered).
- gecerli  output  1  bit_cikisi is valid (registered).
- son  output  1  bit_cikisi is the final bit of the word (registered).

Behaviour:
- Reset (reset=0, asynchronous):
  - gecerli=0, bit_cikisi=0, son=0; shift register and counter cleared.
  - Key table restored to the package defaults.
  - Reset mid-word aborts the word; no further bits are emitted.
- Cipher, with K = key[secim][BIT-1:0]:
  - mod=1: C = rotl(veri ^ K, ROT mod BIT).
  - mod=0: P = rotr(veri, ROT mod BIT) ^ K, the exact inverse of mod=1.
  - ROT mod BIT = 0 means no rotation.
- hazir = ~gecerli | (son & alici_hazir), so a new word can be accepted on the same edge the last bit is consumed.
- States: BOSTA (gecerli=0) and GONDER (gecerli=1).
- BOSTA -> GONDER:
  - Triggered on an edge with basla=1.
  - The result is loaded into the shift register.
  - gecerli becomes 1 and bit_cikisi shows the first bit (bit 0, or bit BIT-1 when ILK_MSB=1).
  - Latency from acceptance edge to first valid bit is 1 cycle.
  - son is 1 on that first bit only when BIT... never true for BIT>=2; son marks only the final bit.
- GONDER, edge with alici_hazir=1:
  - Not the last bit: advance to the next bit in order; son=1 when the counter reaches BIT-1.
  - Last bit and basla=1: accept the new word immediately; gecerli stays 1, no bubble.
  - Last bit and basla=0: go to BOSTA, gecerli=0, son=0.
- GONDER, alici_hazir=0: bit_cikisi, gecerli and son hold unchanged indefinitely.
- basla while hazir=0 is ignored, with no queuing. mod, secim and veri are don't-care outside acceptance.
- Key writes:
  - A write takes effect at the edge it is asserted.
  - A write to the same index on the acceptance edge: the cipher uses the pre-write key.
  - Writes never affect a word already loaded.
- Counter width is $clog2(BIT) and it wraps to 0 on each new acceptance.
- Exactly BIT handshakes occur per word.

Decomposition:
- Package sifreleme_pkg holds:
  - the 8 default 64-bit keys: BABA1453DEDE1071, ACAB0909BACA0707, ADAB0606DADA0505, AAAA0000FFFF5555, CAAA0101CAAA0101, AACA0606AACA0606, CAAA1717CAAA1717, AAAA0000FFFF5555;
  - the BOSTA/GONDER state encoding;
  - the key-table depth constant (8).
- Sub-module anahtar_tablosu: 8x64 register file with async-reset defaults, one synchronous write port and one combinational read port.

Test Plan:
- BIT=4, ROT=2, alici_hazir=1, mod=1, secim=0, veri=4'h6 -> C=4'hD; bits 1,0,1,1 on consecutive cycles starting 1 cycle after acceptance; son high on 4th bit only; gecerli low afterwards.
- Same configuration, mod=0, veri=4'hD -> plaintext 4'h6 streamed 0,1,1,0; also secim=3, veri=4'hA, mod=1 -> 4'hF.
- Back-pressure: alici_hazir=0 for 3 cycles after the 2nd bit -> bit_cikisi, gecerli and son frozen; the stream resumes with the 3rd bit; 4 handshakes total.
- Back-to-back: basla held high with two words -> 8 consecutive valid bits with no gecerli gap; basla during the first word's bits 1..3 is ignored.
- Key write anahtar_adres=0, anahtar_veri=64'h0 on the acceptance edge of veri=4'h6 -> old key is used (4'hD); the next word uses key 0 -> rotl(4'h6,2)=4'h9.
- Reset low mid-word -> outputs 0 immediately (asynchronous); key 0 reads the default again; ILK_MSB=1 rerun of the first case -> bits 1,1,0,1.
